// File: rtl/barrel_unrotator_seq_if.sv
// Request/result handshake bundle for the sequential barrel un-rotator.
// The producer and consumer side both live on the master modport.
interface barrel_unrotator_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] shiftedNum;
    logic [AMT_W-1:0] amt;
    logic             lr;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] num;

    modport master (
        output inValid,
        input  inReady,
        output shiftedNum,
        output amt,
        output lr,
        input  outValid,
        output outReady,
        input  num
    );

    modport slave (
        input  inValid,
        output inReady,
        input  shiftedNum,
        input  amt,
        input  lr,
        output outValid,
        input  outReady,
        output num
    );
endinterface

// File: rtl/barrel_unrotator_seq.sv
// Restores an operand that was rotated by amt in direction lr, undoing the
// rotation one bit position per clock and holding the result until taken.
module barrel_unrotator_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic                   clk,
    input logic                   reset,
    barrel_unrotator_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             lr_q, lr_d;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        lr_d    = lr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.inValid) begin
                    num_d   = bus.shiftedNum;
                    cnt_d   = bus.amt;
                    lr_d    = bus.lr;
                    state_d = (bus.amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Undo the original direction: left rotations are reversed by rotating right.
                if (lr_q)
                    num_d = {num_q[WIDTH-2:0], num_q[WIDTH-1]};
                else
                    num_d = {num_q[0], num_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.outReady)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            lr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
        end
    end

    assign bus.inReady  = (state_q == S_IDLE) && !reset;
    assign bus.outValid = (state_q == S_DONE);
    assign bus.num      = num_q;
endmodule

// File: tb/tb_barrel_unrotator_seq.sv
// Directed bench for barrel_unrotator_seq: hand-computed un-rotation results,
// handshake timing, backpressure, mid-operation reset and input stability.
module tb_barrel_unrotator_seq;
    logic clk = 1'b0;
    logic reset;
    int   compare_count  = 0;
    int   mismatch_count = 0;

    barrel_unrotator_seq_if #(.WIDTH(8), .AMT_W(3)) bus ();

    barrel_unrotator_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for inReady, then presents one request for exactly one accept edge.
    task automatic applyStimulus(input logic [7:0] shifted, input logic [2:0] amt_in,
                                 input logic lr_in);
        int waited = 0;
        while (!bus.inReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("acceptReady", 32'(bus.inReady), 32'd1);
        bus.shiftedNum = shifted;
        bus.amt        = amt_in;
        bus.lr         = lr_in;
        bus.inValid    = 1'b1;
        @(negedge clk);
        bus.inValid    = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input logic [7:0] shifted,
                               input logic [2:0] amt_in, input logic lr_in,
                               input logic [7:0] expected, input int hold_cycles,
                               input bit scramble);
        applyStimulus(shifted, amt_in, lr_in);
        for (int k = 0; k <= int'(amt_in); k++) begin
            if (k > 0) @(negedge clk);
            checkOutput({tag, "_outValid"}, 32'(bus.outValid), 32'(k == int'(amt_in)));
            checkOutput({tag, "_inReadyBusy"}, 32'(bus.inReady), 32'd0);
            if (scramble && k < int'(amt_in)) begin
                bus.shiftedNum = ~shifted;
                bus.amt        = ~amt_in;
                bus.lr         = ~lr_in;
                bus.inValid    = 1'b1;
            end else begin
                bus.inValid    = 1'b0;
            end
        end
        checkOutput({tag, "_num"}, 32'(bus.num), 32'(expected));
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            checkOutput({tag, "_holdValid"}, 32'(bus.outValid), 32'd1);
            checkOutput({tag, "_holdNum"}, 32'(bus.num), 32'(expected));
        end
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
        checkOutput({tag, "_doneValid"}, 32'(bus.outValid), 32'd0);
        checkOutput({tag, "_backReady"}, 32'(bus.inReady), 32'd1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.inValid    = 1'b0;
        bus.shiftedNum = '0;
        bus.amt        = '0;
        bus.lr         = 1'b0;
        bus.outReady   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_inReady", 32'(bus.inReady), 32'd0);
        checkOutput("rst_outValid", 32'(bus.outValid), 32'd0);
        checkOutput("rst_num", 32'(bus.num), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_inReadyAfter", 32'(bus.inReady), 32'd1);

        runAndCheck("rotLeft",  8'b10111000, 3'b110, 1'b0, 8'b11100010, 0, 1'b0);
        runAndCheck("rotRight", 8'b10101100, 3'b001, 1'b1, 8'b01011001, 0, 1'b0);
        runAndCheck("zeroAmt",  8'b00000001, 3'b000, 1'b0, 8'b00000001, 0, 1'b0);
        runAndCheck("maxAmt",   8'b10000011, 3'b111, 1'b0, 8'b00000111, 5, 1'b0);

        // Abandon a request in SHIFT: reset is seen on the third edge after accept.
        applyStimulus(8'b00100010, 3'b111, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRst_outValid", 32'(bus.outValid), 32'd0);
        checkOutput("midRst_num", 32'(bus.num), 32'd0);
        checkOutput("midRst_inReady", 32'(bus.inReady), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midRst_idle", 32'(bus.inReady), 32'd1);
        checkOutput("midRst_idleValid", 32'(bus.outValid), 32'd0);
        runAndCheck("afterRst", 8'b00100010, 3'b111, 1'b1, 8'b00010001, 1, 1'b0);

        runAndCheck("stable",   8'b11001010, 3'b101, 1'b0, 8'b01010110, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
